alu_sched: RTL
==============

Name: alu_sched

Overview:
Sequencer and arbiter that shares one structural 16-bit ALU between two requesters. The ALU ops are AND, NOT, ADD and per-byte SAT add. The block accepts operations over valid/ready handshakes and arbitrates round-robin. It holds operands stable on the ALU inputs for a programmable settle time, because the nand2$-based ALU is slow combinational logic. It then returns the registered result with a requester ID over a valid/ready response channel.

Parameters:
WIDTH, 16, operand/result width (ALU datapath width)
ALU_LAT, 2, EXEC cycles operands are held before alu_out is sampled; legal range 1..15; 0 illegal

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_op  in  2  00 AND, 01 NOT b, 10 ADD, 11 SAT
req0_a  in  WIDTH  operand a
req0_b  in  WIDTH  operand b
req1_valid/req1_ready/req1_op/req1_a/req1_b  same as requester 0
alu_a  out  WIDTH  registered operand a to ALU
alu_b  out  WIDTH  registered operand b to ALU
alu_s  out  2  registered op select to ALU
alu_out  in  WIDTH  ALU result
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester that issued the result
rsp_data  out  WIDTH  registered result

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE, rr pointer to 0, and the EXEC counter clears.
  - alu_a, alu_b, alu_s, rsp_data and rsp_id are 0.
  - rsp_valid, req0_ready and req1_ready are 0.
  - Deassertion takes effect at the first rising clk edge with rst_n=1.
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE:
  - reqX_ready is combinational and equals (state==IDLE) && grantX. At most one ready is high.
  - Grant rule: if only one valid is high, that requester wins. If both are high, the requester selected by the rr pointer wins.
  - On a handshake at the clock edge:
    - Capture op/a/b into alu_s/alu_a/alu_b.
    - Capture the winner's index into rsp_id.
    - Set the rr pointer to the non-winner.
    - Load the counter with ALU_LAT-1 and go to EXEC.
  - With no valid, stay in IDLE; the alu_* registers keep their last values (no toggling).
- EXEC:
  - alu_* are held stable; both readys are 0.
  - The counter decrements each cycle.
  - On the cycle the counter is 0: rsp_data <= alu_out, rsp_valid <= 1, go to RESP.
  - EXEC therefore lasts exactly ALU_LAT cycles.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and alu_* are held stable; both readys are 0.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, go to IDLE.
  - A new grant is possible only in the IDLE cycle that follows; there is no IDLE/RESP overlap.
- Timing with ALU_LAT=2, requester always valid and rsp_ready tied high:
  - Accept at cycle N.
  - rsp_valid is high in cycle N+3.
  - Next accept at cycle N+4.
  - Throughput is one op per ALU_LAT+2 cycles.
- Requester rules:
  - A requester must hold valid and its payload until ready is seen.
  - The scheduler does not check this.
  - A requester that drops valid before ready loses its turn; the rr pointer is unchanged.
- Fairness: with both valid continuously, grants alternate 0,1,0,1, and the first grant after reset goes to 0.
- The scheduler performs no arithmetic.
  - Results, including SAT per-byte clamping to 0x7F/0x80, come solely from alu_out.
  - rsp_data is alu_out sampled verbatim.
- Reset asserted in EXEC or RESP: the in-flight op is discarded, no response is produced, and all outputs return to reset values immediately.
- Backpressure: rsp_ready held low keeps RESP indefinitely; pending requests see ready=0.

Optional Feature:
- Macro: ALU_SCHED_STATS_EN.
- Defined:
  - Adds output ports stat0_cnt and stat1_cnt, each 16 bits.
  - Each counts accepted ops for its requester, increments on the handshake edge, saturates at 0xFFFF and clears on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single op, ALU_LAT=2, rsp_ready=1: req0 ADD a=0x0F0F b=0xF0F0 at cycle 0 -> req0_ready=1 at cycle 0; alu_s=10 from cycle 1; rsp_valid=1 at cycle 3 with rsp_id=0, rsp_data=0xFFFF; second op accepted no earlier than cycle 4.
- Arbitration: req0 AND 0xCCCC/0x6666 and req1 NOT b=0xCC77 both valid from reset -> first response id=0, data 0x4444; second response id=1, data 0x3388; a third pair yields id order 0,1.
- SAT path: req1 op=11 a=b=0x1282 -> rsp_data=0x2480, rsp_id=1.
- Backpressure: rsp_ready=0 for 10 cycles while req0 is valid -> rsp_valid and rsp_data stable, req0_ready=0 throughout; rsp_ready=1 -> IDLE the next cycle, req0 accepted that cycle.
- Reset mid-EXEC: rst_n=0 one cycle after accept -> rsp_valid never asserts, alu_a=0, rr pointer=0; the next pair of simultaneous requests grants 0 first.
- With ALU_SCHED_STATS_EN defined: 3 req0 ops and 2 req1 ops -> stat0_cnt=3, stat1_cnt=2; after reset both read 0.

Source files
------------

// File: rtl/alu_sched.sv
// ---------------------------------------------------------------------------
// alu_sched
//   Shares one slow, structural 16-bit ALU (AND / NOT b / ADD / per-byte SAT)
//   between two requesters. Ops are accepted over valid/ready with round-robin
//   arbitration. The operands are held stable on alu_a/alu_b/alu_s for ALU_LAT
//   cycles. alu_out is then registered and returned with the issuing
//   requester's ID over a valid/ready response channel.
//
// Parameters
//   WIDTH    datapath width (default 16)
//   ALU_LAT  EXEC cycles before alu_out is sampled, legal 1..15
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b         request channel N (N = 0, 1)
//                                   op: 00 AND, 01 NOT b, 10 ADD, 11 SAT
//   alu_a, alu_b, alu_s             registered operands/op select to the ALU
//   alu_out                         ALU result (combinational, slow)
//   rsp_valid/ready/id/data         response channel
//
// Optional feature (macro ALU_SCHED_STATS_EN)
//   Adds stat0_cnt / stat1_cnt, saturating 16-bit counts of accepted ops
//   per requester, cleared by reset.
// ---------------------------------------------------------------------------
module alu_sched #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_s,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]      stat0_cnt,
  output logic [15:0]      stat1_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_t           state_reg, state_next;
  logic             rr_reg;        // requester favoured on a tie
  logic [3:0]       cnt_reg;       // EXEC cycles remaining after this one
  logic [WIDTH-1:0] alu_a_reg, alu_b_reg, rsp_data_reg;
  logic [1:0]       alu_s_reg;
  logic             rsp_valid_reg, rsp_id_reg;

  logic [1:0]       grant;
  logic [1:0]       ready_vec;
  logic             accept;
  logic             winner;        // index of the requester granted this cycle

  // Round-robin only matters when both requesters are valid.
  assign grant[0] = req0_valid && (!req1_valid || !rr_reg);
  assign grant[1] = req1_valid && (!req0_valid ||  rr_reg);

  // rst_n gates the readys so no handshake is offered while reset is held.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = rst_n && (state_reg == IDLE) && grant[gi];
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;
  assign winner     = ready_vec[1];

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)          state_next = EXEC;
      EXEC:    if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: operand capture, settle counter, result capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg        <= 1'b0;
      cnt_reg       <= 4'd0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_s_reg     <= 2'b00;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // alu_* only change on a handshake so the ALU inputs never toggle idly.
          if (accept) begin
            alu_a_reg  <= winner ? req1_a  : req0_a;
            alu_b_reg  <= winner ? req1_b  : req0_b;
            alu_s_reg  <= winner ? req1_op : req0_op;
            rsp_id_reg <= winner;
            rr_reg     <= ~winner;
            cnt_reg    <= CNT_LOAD;
          end
        end
        EXEC: begin
          if (cnt_reg == 4'd0) begin
            rsp_data_reg  <= alu_out;
            rsp_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_s     = alu_s_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;

`ifdef ALU_SCHED_STATS_EN
  // -------------------------------------------------------------------------
  // Per-requester accepted-op counters, saturating at all-ones
  // -------------------------------------------------------------------------
  logic [15:0] stat_cnt_reg [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stat_cnt_reg[gi] <= 16'd0;
        end else if (ready_vec[gi] && (stat_cnt_reg[gi] != 16'hFFFF)) begin
          stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign stat0_cnt = stat_cnt_reg[0];
  assign stat1_cnt = stat_cnt_reg[1];
`endif

endmodule
